// File: rtl/deserializer_pkg.sv
// Shared types and constants for the serial-link receive path.
package deserializer_pkg;

  typedef enum logic {
    IDLE_S,
    RECV_S
  } state_t;

  // Frames shorter than this are discarded; matches the serializer's modifier ignore rule.
  localparam int unsigned MIN_FRAME_LEN = 3;

endpackage

// File: rtl/deserializer.sv
// Rebuilds a left-aligned parallel word plus bit-count modifier from an
// MSB-first serial stream; frames end on valid drop or after a full bus width.
module deserializer
  import deserializer_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  output logic [DATA_MOD_WIDTH-1:0] data_mod_o,
  output logic                      data_val_o,
  output logic                      drop_o,
  output logic                      busy_o
);

  localparam int W     = DATA_BUS_WIDTH;
  localparam int IDX_W = $clog2(W);
  localparam int CNT_W = $clog2(W) + 1;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [W-1:0]              shreg_q, shreg_d;
  logic [W-1:0]              data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0] mod_q, mod_d;
  logic                      val_q, val_d;
  logic                      drop_q, drop_d;
  logic [IDX_W-1:0]          pos;

  // In RECV cnt is always below W, so the low bits address the next free slot.
  assign pos = IDX_W'(W - 1) - cnt_q[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (ser_data_val_i) begin
          shreg_d        = '0;
          shreg_d[W-1]   = ser_data_i;
          cnt_d          = CNT_W'(1);
          state_d        = RECV_S;
        end
      end
      RECV_S: begin
        if (ser_data_val_i) begin
          shreg_d[pos] = ser_data_i;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            data_d  = shreg_d;
            mod_d   = '0;
            val_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE_S;
          end
        end else begin
          if (cnt_q >= CNT_W'(MIN_FRAME_LEN)) begin
            data_d = shreg_q;
            mod_d  = DATA_MOD_WIDTH'(cnt_q);
            val_d  = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE_S;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = val_q;
  assign drop_o     = drop_q;
  assign busy_o     = (state_q == RECV_S);

endmodule

// File: tb/tb_deserializer.sv
// Directed-vector bench for the deserializer at W = 16.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ser_data;
  logic        ser_val;
  logic [15:0] data_o;
  logic [3:0]  data_mod_o;
  logic        data_val_o;
  logic        drop_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] word;
    int          n;
    logic [15:0] exp_data;
    logic [3:0]  exp_mod;
    bit          exp_drop;
  } vec_t;

  vec_t vecs[13];

  deserializer #(.DATA_BUS_WIDTH(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ser_data_i     (ser_data),
    .ser_data_val_i (ser_val),
    .data_o         (data_o),
    .data_mod_o     (data_mod_o),
    .data_val_o     (data_val_o),
    .drop_o         (drop_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives n bits MSB-first starting now (cycle t); for n < 16 adds one invalid
  // terminator cycle. Returns positioned in the cycle where the strobe is due.
  task automatic run_frame(input string tag, input logic [15:0] word, input int n,
                           input logic [15:0] exp_data, input logic [3:0] exp_mod,
                           input bit exp_drop);
    logic [15:0] sh;
    int          timing_err;
    sh         = word;
    timing_err = 0;
    for (int i = 0; i < n; i++) begin
      ser_data = sh[15];
      ser_val  = 1'b1;
      sh       = sh << 1;
      tick();
      if (i < n - 1 || n < 16) begin
        if (data_val_o !== 1'b0 || drop_o !== 1'b0 || busy_o !== 1'b1) timing_err++;
      end
    end
    if (n < 16) begin
      ser_val  = 1'b0;
      ser_data = 1'b0;
      tick();
    end
    check({tag, " timing"}, 16'(timing_err), 16'd0);
    check({tag, " strobe"}, {14'd0, data_val_o, drop_o}, exp_drop ? 16'd1 : 16'd2);
    check({tag, " busy"}, {15'd0, busy_o}, 16'd0);
    check({tag, " data"}, data_o, exp_data);
    check({tag, " mod"}, {12'd0, data_mod_o}, {12'd0, exp_mod});
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] prev_data;
    logic [3:0]  prev_mod;
    int          n;
    int          strobes;

    vecs[0]  = '{16'hA5C3, 16, 16'hA5C3, 4'd0,  1'b0};
    vecs[1]  = '{16'hB000, 5,  16'hB000, 4'd5,  1'b0};
    vecs[2]  = '{16'hC000, 2,  16'hB000, 4'd5,  1'b1};
    vecs[3]  = '{16'h8000, 1,  16'hB000, 4'd5,  1'b1};
    vecs[4]  = '{16'hE000, 3,  16'hE000, 4'd3,  1'b0};
    vecs[5]  = '{16'hFFFF, 16, 16'hFFFF, 4'd0,  1'b0};
    vecs[6]  = '{16'hF000, 4,  16'hF000, 4'd4,  1'b0};
    vecs[7]  = '{16'hFFFF, 15, 16'hFFFE, 4'd15, 1'b0};
    vecs[8]  = '{16'h5555, 8,  16'h5500, 4'd8,  1'b0};
    vecs[9]  = '{16'h4000, 2,  16'h5500, 4'd8,  1'b1};
    vecs[10] = '{16'h1234, 16, 16'h1234, 4'd0,  1'b0};
    vecs[11] = '{16'h8001, 16, 16'h8001, 4'd0,  1'b0};
    vecs[12] = '{16'h6000, 3,  16'h6000, 4'd3,  1'b0};

    rst_n    = 1'b0;
    ser_data = 1'b0;
    ser_val  = 1'b0;
    tick();
    tick();
    check("reset data", data_o, 16'h0000);
    check("reset ctl", {11'd0, data_mod_o, data_val_o, drop_o, busy_o}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Full frames run straight into the next vector, covering back-to-back entry.
    for (int k = 0; k < 13; k++) begin
      run_frame($sformatf("vec%0d", k), vecs[k].word, vecs[k].n,
                vecs[k].exp_data, vecs[k].exp_mod, vecs[k].exp_drop);
    end

    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      n = int'($urandom_range(16, 3));
      run_frame($sformatf("rnd%0d", k), w, n, w & ~(16'hFFFF >> n), 4'(n), 1'b0);
    end

    // Reset mid-frame: seven bits in, then asynchronous reset between edges.
    run_frame("pre_rst", 16'hB000, 5, 16'hB000, 4'd5, 1'b0);
    w = 16'hFFFF;
    for (int i = 0; i < 7; i++) begin
      ser_data = w[15];
      ser_val  = 1'b1;
      w        = w << 1;
      tick();
    end
    check("mid busy", {15'd0, busy_o}, 16'd1);
    ser_val = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async data", data_o, 16'h0000);
    check("async ctl", {11'd0, data_mod_o, data_val_o, drop_o, busy_o}, 16'd0);
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_val_o !== 1'b0 || drop_o !== 1'b0) strobes++;
    end
    rst_n = 1'b1;
    tick();
    if (data_val_o !== 1'b0 || drop_o !== 1'b0) strobes++;
    check("rst no strobe", 16'(strobes), 16'd0);
    run_frame("post_rst", 16'h1234, 16, 16'h1234, 4'd0, 1'b0);

    // Strobe must last only one cycle and outputs hold afterwards.
    prev_data = data_o;
    prev_mod  = data_mod_o;
    ser_val   = 1'b0;
    tick();
    check("strobe width", {15'd0, data_val_o}, 16'd0);
    check("hold data", data_o, prev_data);
    check("hold mod", {12'd0, data_mod_o}, {12'd0, prev_mod});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
